control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have the following ports, one per line: name, direction, width, meaning.
REQ-002 CLKb  in  1  Single clock; all state updates on the rising edge. The register file it drives samples on the falling edge.
REQ-003 RST  in  1  Reset; synchronous, active-high.
REQ-004 INSTR  in  10  Instruction word: [9:6] opcode, [5:4] Rx, [3:2] Ry, [1:0] ignored.
REQ-005 INSTR_VALID  in  1  Instruction offered; accepted on a rising edge where INSTR_VALID=1 and READY=1.
REQ-006 DIN  in  10  Immediate data for LOAD; sampled on the accept edge.
REQ-007 Q0, Q1  in  10 each  Register-file read data; may be high-Z outside READ.
REQ-008 D  out  10  Register-file write data.
REQ-009 ENW, ENR0, ENR1  out  1 each  Register-file write enable and read-port enables.
REQ-010 WRA, RDA0, RDA1  out  2 each  Register-file write address and read addresses.
REQ-011 READY  out  1  High only in state IDLE.
REQ-012 DONE  out  1  One-cycle completion pulse.
REQ-013 ERR  out  1  One-cycle illegal-opcode pulse, coincident with DONE.
REQ-014 CARRY, ZERO  out  1 each  Registered ALU flags.

Function
REQ-015 The block SHALL implement the states IDLE, READ, EXEC and WRITE, held in a registered state variable.
REQ-016 On accept, the block SHALL latch INSTR and DIN; RDA0=WRA=Rx and RDA1=Ry SHALL be driven from the latched copy until the next accept.
REQ-017 The opcodes SHALL be: 0000 LOAD Rx<=DIN; 0001 MOV Rx<=Ry; 0010 ADD Rx<=Rx+Ry; 0011 SUB Rx<=Rx-Ry; 0100 XOR Rx<=Rx^Ry; 0101 SHL Rx<=Rx<<1 with zero fill; all others are illegal.
REQ-018 State transitions SHALL be:
- IDLE -> READ on accepting MOV, ADD, SUB, XOR or SHL.
- IDLE -> WRITE on accepting LOAD.
- IDLE -> IDLE on accepting an illegal opcode.
- READ -> EXEC -> WRITE -> IDLE unconditionally, one cycle each.
REQ-019 In READ, ENR0 SHALL be 1 for ADD, SUB, XOR and SHL, and ENR1 SHALL be 1 for MOV, ADD, SUB and XOR; both SHALL be 0 in every other state.
REQ-020 On the READ->EXEC edge, the block SHALL capture Q0 and Q1 into operand registers; Q0 and Q1 SHALL NOT be sampled at any other time.
REQ-021 On the EXEC->WRITE edge, the block SHALL compute and register the 10-bit result together with an internal carry bit.
REQ-022 For LOAD, the result register SHALL take the latched DIN on the accept edge.
REQ-023 In WRITE, ENW SHALL be 1 and D SHALL equal the result register; in all other states ENW SHALL be 0 and D SHALL hold its last value.
REQ-024 Carry SHALL be defined as:
- ADD: bit 10 of the 11-bit sum.
- SUB: borrow, i.e. 1 iff Rx<Ry (unsigned).
- SHL: Rx[9].
- XOR: 0.
REQ-025 On the WRITE->IDLE edge, CARRY and ZERO (ZERO = result==0) SHALL update for ADD, SUB, XOR and SHL only; for LOAD and MOV they SHALL hold.
REQ-026 DONE SHALL be 1 for exactly the one cycle following WRITE, or following the accept of an illegal opcode.
REQ-027 ERR SHALL be 1 only in that same cycle, and only for an illegal opcode.
REQ-028 An illegal opcode SHALL produce no ENW and no ENR0/ENR1 activity.
REQ-029 Latency SHALL be counted from the accept edge to DONE high: 4 cycles for register ops, 2 cycles for LOAD, 1 cycle for illegal opcodes.
REQ-030 A new instruction MAY be accepted in the same cycle DONE is high, because READY=1 in IDLE.
REQ-031 While READY=0, INSTR_VALID and INSTR SHALL be ignored and no latched field SHALL change.
REQ-032 When Rx==Ry, operations SHALL use the same register for both operands (e.g. SUB R1,R1 gives 0, ZERO=1, CARRY=0).

Reset
REQ-033 When RST=1 on a rising edge, the block SHALL set: state=IDLE; ENW=ENR0=ENR1=0; D=0; WRA=RDA0=RDA1=0; DONE=ERR=0; CARRY=ZERO=0; operand and result registers=0.
REQ-034 RST SHALL take priority over all transitions, including mid-operation.
REQ-035 An RST asserted in READ, EXEC or WRITE SHALL abort the instruction with no DONE pulse; when asserted in WRITE, ENW SHALL be 0 from the following cycle.
REQ-036 READY SHALL be 1 in the first cycle after RST deasserts.

Verification
REQ-037 LOAD R2 with DIN=10'h155 -> ENW=1, WRA=2, D=10'h155 one cycle after accept; DONE one cycle later; flags unchanged.
REQ-038 With R0=10'h3FF and R1=10'h001, ADD R0,R1 -> ENR0=ENR1=1 with RDA0=0, RDA1=1 in READ; D=10'h000 in WRITE; then CARRY=1, ZERO=1; DONE 4 cycles after accept.
REQ-039 With R3=10'h005 and R2=10'h007, SUB R3,R2 -> D=10'h3FE, CARRY=1, ZERO=0.
REQ-040 With R1=10'h201, SHL R1 -> ENR1=0 in READ; D=10'h002, CARRY=1.
REQ-041 Opcode 1111 -> DONE=ERR=1 in the next cycle; no ENW/ENR activity; READY stays 1; a second INSTR_VALID during an ADD's EXEC is ignored.
REQ-042 RST asserted during EXEC of an ADD -> no ENW, no DONE, all outputs at reset values, READY=1 after release.

Source files
------------

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Purpose:
//   Instruction sequencer for a four-entry, 10-bit register file. It accepts
//   one instruction at a time and walks it through IDLE -> READ -> EXEC ->
//   WRITE. It drives the register-file enables and addresses, runs a small
//   ALU (LOAD, MOV, ADD, SUB, XOR, SHL) and keeps registered CARRY/ZERO
//   flags. Illegal opcodes finish in one cycle with an ERR pulse.
//
// Ports:
//   CLKb         in   1   clock, rising-edge active
//   RST          in   1   synchronous active-high reset
//   INSTR        in  10   [9:6] opcode, [5:4] Rx, [3:2] Ry, [1:0] ignored
//   INSTR_VALID  in   1   instruction offered, taken when READY=1
//   DIN          in  10   immediate data for LOAD
//   Q0, Q1       in  10   register-file read data (port 0 / port 1)
//   D            out 10   register-file write data
//   ENW          out  1   register-file write enable
//   ENR0, ENR1   out  1   register-file read-port enables
//   WRA          out  2   write address (Rx)
//   RDA0, RDA1   out  2   read addresses (Rx, Ry)
//   READY        out  1   high while idle
//   DONE         out  1   one-cycle completion pulse
//   ERR          out  1   one-cycle illegal-opcode pulse (with DONE)
//   CARRY, ZERO  out  1   registered ALU flags
// ---------------------------------------------------------------------------
module control_sequencer (
    input  logic       CLKb,
    input  logic       RST,
    input  logic [9:0] INSTR,
    input  logic       INSTR_VALID,
    input  logic [9:0] DIN,
    input  logic [9:0] Q0,
    input  logic [9:0] Q1,
    output logic [9:0] D,
    output logic       ENW,
    output logic       ENR0,
    output logic       ENR1,
    output logic [1:0] WRA,
    output logic [1:0] RDA0,
    output logic [1:0] RDA1,
    output logic       READY,
    output logic       DONE,
    output logic       ERR,
    output logic       CARRY,
    output logic       ZERO
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EXEC,
        WRITE
    } state_t;

    localparam logic [3:0] OP_LOAD = 4'b0000;
    localparam logic [3:0] OP_MOV  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SHL  = 4'b0101;

    state_t      state;
    state_t      next_state;

    logic        accept;
    logic [3:0]  in_opcode;
    logic        in_legal;

    logic [3:0]  opcode;
    logic [1:0]  rx;
    logic [1:0]  ry;

    logic [9:0]  operand_a;
    logic [9:0]  operand_b;
    logic [9:0]  result;
    logic        result_carry;

    logic        uses_rx;
    logic        uses_ry;
    logic        sets_flags;

    logic [10:0] alu_sum;
    logic [9:0]  alu_result;
    logic        alu_carry;

    logic        unused_instr_bits;

    assign in_opcode         = INSTR[9:6];
    assign in_legal          = (in_opcode <= OP_SHL);
    assign unused_instr_bits = ^INSTR[1:0];

    // The latched instruction drives the addresses until the next accept;
    // D is simply the result register, so it holds outside WRITE.
    assign WRA  = rx;
    assign RDA0 = rx;
    assign RDA1 = ry;
    assign D    = result;

    // State register.
    always_ff @(posedge CLKb) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and state-decoded outputs. READY is only ever high in IDLE,
    // so an accept can only happen from IDLE and busy cycles ignore INSTR.
    always_comb begin
        next_state = state;
        READY      = 1'b0;
        ENW        = 1'b0;
        ENR0       = 1'b0;
        ENR1       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                READY = 1'b1;
                if (INSTR_VALID) begin
                    accept = 1'b1;
                    if (!in_legal) begin
                        next_state = IDLE;
                    end else if (in_opcode == OP_LOAD) begin
                        next_state = WRITE;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            READ: begin
                ENR0       = uses_rx;
                ENR1       = uses_ry;
                next_state = EXEC;
            end
            EXEC: begin
                next_state = WRITE;
            end
            WRITE: begin
                ENW        = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Which operands each latched opcode reads, and whether it updates flags.
    // LOAD and MOV leave CARRY/ZERO untouched.
    always_comb begin
        uses_rx    = 1'b0;
        uses_ry    = 1'b0;
        sets_flags = 1'b0;
        case (opcode)
            OP_MOV: begin
                uses_ry = 1'b1;
            end
            OP_ADD, OP_SUB, OP_XOR: begin
                uses_rx    = 1'b1;
                uses_ry    = 1'b1;
                sets_flags = 1'b1;
            end
            OP_SHL: begin
                uses_rx    = 1'b1;
                sets_flags = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ALU. SUB carry is the unsigned borrow; MOV passes Ry through.
    always_comb begin
        alu_sum    = {1'b0, operand_a} + {1'b0, operand_b};
        alu_result = operand_b;
        alu_carry  = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_result = alu_sum[9:0];
                alu_carry  = alu_sum[10];
            end
            OP_SUB: begin
                alu_result = operand_a - operand_b;
                alu_carry  = (operand_a < operand_b);
            end
            OP_XOR: begin
                alu_result = operand_a ^ operand_b;
            end
            OP_SHL: begin
                alu_result = {operand_a[8:0], 1'b0};
                alu_carry  = operand_a[9];
            end
            default: begin
            end
        endcase
    end

    // Datapath: instruction latch, operand capture (only on READ->EXEC),
    // result/carry capture, and the DONE/ERR/flag updates.
    always_ff @(posedge CLKb) begin
        if (RST) begin
            opcode       <= 4'd0;
            rx           <= 2'd0;
            ry           <= 2'd0;
            operand_a    <= 10'd0;
            operand_b    <= 10'd0;
            result       <= 10'd0;
            result_carry <= 1'b0;
            DONE         <= 1'b0;
            ERR          <= 1'b0;
            CARRY        <= 1'b0;
            ZERO         <= 1'b0;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;

            if (accept) begin
                opcode <= in_opcode;
                rx     <= INSTR[5:4];
                ry     <= INSTR[3:2];
                if (in_opcode == OP_LOAD) begin
                    result <= DIN;
                end
                if (!in_legal) begin
                    DONE <= 1'b1;
                    ERR  <= 1'b1;
                end
            end

            if (state == READ) begin
                operand_a <= Q0;
                operand_b <= Q1;
            end

            if (state == EXEC) begin
                result       <= alu_result;
                result_carry <= alu_carry;
            end

            if (state == WRITE) begin
                DONE <= 1'b1;
                if (sets_flags) begin
                    CARRY <= result_carry;
                    ZERO  <= (result == 10'd0);
                end
            end
        end
    end

endmodule
